// File: rtl/loa_if.sv
// Operand/result handshake bundle for the lower-part-OR pipelined adder.
// The producer/consumer side uses master; the adder uses slave.
interface loa_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             approx_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output in_valid, A, B, Cin, approx_en, out_ready,
    input  in_ready, out_valid, Sum, Cout
  );

  modport slave (
    input  in_valid, A, B, Cin, approx_en, out_ready,
    output in_ready, out_valid, Sum, Cout
  );
endinterface

// File: rtl/loa_pipe_adder.sv
// Segmented pipelined adder with optional lower-part-OR approximation.
// Each stage adds one SEG_W slice and passes its carry and the operands on.
module loa_pipe_adder #(
  parameter int WIDTH       = 32,
  parameter int SEG_W       = 8,
  parameter int APPROX_BITS = 8
) (
  input  logic  clk,
  input  logic  rst,
  loa_if.slave  bus
);
  localparam int NSEG = WIDTH / SEG_W;

  // Bits below APPROX_BITS are ORed when apx is set; the carry leaving the
  // approximate part is the AND of its top bit pair, the incoming carry is dropped.
  function automatic logic [SEG_W:0] seg_add(
    input logic [SEG_W-1:0] a,
    input logic [SEG_W-1:0] b,
    input logic             cin,
    input logic             apx,
    input int               base
  );
    logic             c;
    logic [SEG_W-1:0] s;
    c = cin;
    s = '0;
    for (int j = 0; j < SEG_W; j++) begin
      if (apx && ((base + j) < APPROX_BITS)) begin
        s[j] = a[j] | b[j];
        c    = ((base + j) == (APPROX_BITS - 1)) ? (a[j] & b[j]) : 1'b0;
      end else begin
        s[j] = a[j] ^ b[j] ^ c;
        c    = (a[j] & b[j]) | (c & (a[j] ^ b[j]));
      end
    end
    return {c, s};
  endfunction

  logic [NSEG-1:0]  r_vld;
  logic [NSEG-1:0]  r_cy;
  logic [NSEG-1:0]  r_apx;
  logic [WIDTH-1:0] r_a   [NSEG];
  logic [WIDTH-1:0] r_b   [NSEG];
  logic [WIDTH-1:0] r_sum [NSEG];

  logic [NSEG-1:0]  w_vin;
  logic [NSEG-1:0]  w_cin;
  logic [NSEG-1:0]  w_apxin;
  logic [WIDTH-1:0] w_ain  [NSEG];
  logic [WIDTH-1:0] w_bin  [NSEG];
  logic [WIDTH-1:0] w_sin  [NSEG];
  logic [SEG_W:0]   w_res  [NSEG];
  logic             w_adv;

  assign w_adv         = !r_vld[NSEG-1] || bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld[NSEG-1];
  assign bus.Sum       = r_sum[NSEG-1];
  assign bus.Cout      = r_cy[NSEG-1];

  // Stage s sees either the new operands (s == 0) or stage s-1's registers.
  for (genvar s = 0; s < NSEG; s++) begin : g_seg
    if (s == 0) begin : g_first
      assign w_vin[s]   = bus.in_valid;
      assign w_ain[s]   = bus.A;
      assign w_bin[s]   = bus.B;
      assign w_cin[s]   = bus.Cin;
      assign w_apxin[s] = bus.approx_en;
      assign w_sin[s]   = '0;
    end else begin : g_next
      assign w_vin[s]   = r_vld[s-1];
      assign w_ain[s]   = r_a[s-1];
      assign w_bin[s]   = r_b[s-1];
      assign w_cin[s]   = r_cy[s-1];
      assign w_apxin[s] = r_apx[s-1];
      assign w_sin[s]   = r_sum[s-1];
    end
    assign w_res[s] = seg_add(w_ain[s][s*SEG_W +: SEG_W], w_bin[s][s*SEG_W +: SEG_W],
                              w_cin[s], w_apxin[s], s * SEG_W);
  end

  // Whole pipeline moves together; bubbles leave data registers untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld           <= '0;
      r_sum[NSEG-1]   <= '0;
      r_cy[NSEG-1]    <= 1'b0;
    end else if (w_adv) begin
      r_vld <= w_vin;
      for (int s = 0; s < NSEG; s++) begin
        if (w_vin[s]) begin
          r_a[s]                     <= w_ain[s];
          r_b[s]                     <= w_bin[s];
          r_apx[s]                   <= w_apxin[s];
          r_cy[s]                    <= w_res[s][SEG_W];
          r_sum[s]                   <= w_sin[s];
          r_sum[s][s*SEG_W +: SEG_W] <= w_res[s][SEG_W-1:0];
        end
      end
    end
  end
endmodule
